atm_keypad_session: RTL and testbench
=====================================

// Module: atm_keypad_session
// PURPOSE
// Customer-side front end driving the ATM controller's inputs from a hex keypad. Assembles ID and
// Password from key strokes, submits them, reads back ErrPass, then turns menu keys into
// Control/Request/Back/Eject commands and latches ErrBalance. Enforces a retry limit with timed
// lockout. Sits between keypad scanner and ATM; all outputs registered.
// PARAMETERS
// MAX_TRIES    3   consecutive ErrPass=1 results before lockout (1..15)
// RESP_WAIT    2   cycles ID/Password are held before ErrPass is sampled (>=1)
// LOCK_CYCLES  16  cycles spent in LOCK before returning to ID entry (>=1)
// PORTS
// Clock      in   1  rising-edge clock
// Reset      in   1  synchronous, active-high; clock Clock
// KeyValid   in   1  one-cycle strobe, KeyCode valid; at most one key per cycle
// KeyCode    in   5  0x00-0x0F hex digit, 0x10 ENTER, 0x11 CLEAR, 0x12 BACK, 0x13 EJECT; others invalid
// ErrPass    in   1  ATM password/ID error (0 = authorised)
// ErrBalance in   1  ATM insufficient-balance error
// ID         out  8  account ID presented to ATM
// Password   out  8  password presented to ATM
// Control    out  3  ATM command: 000 none, 010 SHOW, 011 WITHDRAW, 100 WITHDRAWSHOW, 101 TRANSFER
// Request    out  8  withdrawal amount
// Back       out  1  one-cycle pulse
// Eject      out  1  one-cycle pulse
// Stage      out  3  0 ID, 1 PASS, 2 WAIT, 3 MENU, 4 AMOUNT, 5 LOCK
// Locked     out  1  high while Stage=LOCK
// BalErr     out  1  sticky ErrBalance flag
// KeyReject  out  1  one-cycle pulse: key ignored/illegal
// BEHAVIOUR
// - Reset: all outputs 0 (Stage=ID), try counter 0, menu selection empty, digit count 0. Reset wins over any key.
// - Key sampled on KeyValid; effects visible on outputs the following cycle. Invalid codes -> KeyReject.
// - Digit entry (ID, PASS, AMOUNT fields): field <= {field[3:0],digit}; digit count saturates at 2;
//   3rd digit -> KeyReject, field unchanged. CLEAR zeroes current field and count. ENTER with count<2 -> KeyReject.
// - ID: ENTER(count=2) -> PASS. PASS: ENTER(count=2) -> WAIT, wait counter loaded.
// - WAIT: ID/Password held; all keys -> KeyReject. After RESP_WAIT cycles sample ErrPass:
//   0 -> MENU, tries=0; 1 -> tries+1; if tries reaches MAX_TRIES -> LOCK, else PASS with Password=0, count=0.
// - LOCK: Locked=1, keys rejected, LOCK_CYCLES cycles, then ID with ID=Password=0, tries=0.
// - MENU: digit 2/3/4/5 stores selection (010/011/100/101); other digits -> KeyReject. ENTER with no
//   selection -> KeyReject; sel 011/100 -> AMOUNT (Request field cleared); else Control=sel for exactly 1 cycle.
// - AMOUNT: ENTER(count=2) -> Request holds value, Control=sel for 1 cycle, -> MENU, selection cleared.
// - Request held stable until next AMOUNT entry or EJECT. Control 000 in every other cycle.
// - BACK in MENU/AMOUNT: Back pulse, selection cleared, -> MENU. BACK in ID/PASS -> KeyReject.
// - EJECT in ID/PASS/MENU/AMOUNT: Eject pulse; ID, Password, Request, selection, counts, BalErr cleared; -> ID.
//   tries NOT cleared by EJECT (lockout cannot be dodged). EJECT in WAIT/LOCK -> KeyReject.
// - BalErr: set when ErrBalance=1 sampled in MENU or AMOUNT; cleared on Control pulse cycle, EJECT, Reset.
//   Set and clear same cycle -> clear wins.
// - ErrPass/ErrBalance ignored outside the states above; X on them treated as 1.
// TESTING
// 1 Reset mid-AMOUNT -> next cycle all outputs 0, Stage=0, tries=0.
// 2 Keys 1,2,ENTER,A,5,ENTER, ErrPass=0 -> ID=0x12, Password=0xA5, Stage=2 for 2 cycles, then Stage=3.
// 3 Three wrong passwords (ErrPass=1) -> Locked=1 for exactly 16 cycles, keys give KeyReject; then Stage=0, ID=0.
// 4 MENU: 3,ENTER,4,0,ENTER -> Request=0x40, Control=011 for one cycle, then 000, Stage=3; ErrBalance=1 -> BalErr=1.
// 5 MENU: BACK -> Back one cycle, Stage=3; EJECT -> Eject one cycle, ID/Password/Request/BalErr=0, Stage=0.
// 6 ID: 1,2,3 -> 3rd KeyReject, ID=0x12; CLEAR -> ID=0; ENTER with 1 digit -> KeyReject, Stage stays 0.

Source files
------------

// File: rtl/atm_keypad_session.sv
// Keypad front end for the ATM controller: assembles ID/password, runs the
// authorisation handshake with a retry lockout, then turns menu keys into commands.
module atm_keypad_session #(
  parameter int MAX_TRIES   = 3,
  parameter int RESP_WAIT   = 2,
  parameter int LOCK_CYCLES = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       KeyValid,
  input  logic [4:0] KeyCode,
  input  logic       ErrPass,
  input  logic       ErrBalance,
  output logic [7:0] ID,
  output logic [7:0] Password,
  output logic [2:0] Control,
  output logic [7:0] Request,
  output logic       Back,
  output logic       Eject,
  output logic [2:0] Stage,
  output logic       Locked,
  output logic       BalErr,
  output logic       KeyReject
);

  typedef enum logic [2:0] {
    ST_ID     = 3'd0,
    ST_PASS   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_MENU   = 3'd3,
    ST_AMOUNT = 3'd4,
    ST_LOCK   = 3'd5
  } stage_t;

  localparam logic [4:0] K_ENTER = 5'h10;
  localparam logic [4:0] K_CLEAR = 5'h11;
  localparam logic [4:0] K_BACK  = 5'h12;
  localparam logic [4:0] K_EJECT = 5'h13;

  localparam int TMAX = (RESP_WAIT > LOCK_CYCLES) ? RESP_WAIT : LOCK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] WAIT_LOAD = TW'(RESP_WAIT - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
  localparam logic [3:0]    TRY_LIMIT = 4'(MAX_TRIES);

  stage_t        state;
  logic [1:0]    digits;
  logic [2:0]    sel;
  logic [3:0]    tries;
  logic [TW-1:0] timer;

  logic       is_digit;
  logic [3:0] digit;
  logic       pass_ok;
  logic       bal_hit;
  logic [7:0] field_cur;
  logic [7:0] field_shift;

  assign is_digit = ~KeyCode[4];
  assign digit    = KeyCode[3:0];
  assign Stage    = state;

  // An unknown response must never authorise, so only a clean 0 counts as OK.
  always_comb begin
    pass_ok = 1'b0;
    bal_hit = 1'b1;
    if (ErrPass == 1'b0)    pass_ok = 1'b1;
    if (ErrBalance == 1'b0) bal_hit = 1'b0;
  end

  always_comb begin
    case (state)
      ST_ID:   field_cur = ID;
      ST_PASS: field_cur = Password;
      default: field_cur = Request;
    endcase
    field_shift = {field_cur[3:0], digit};
  end

  // NOTE: all state and outputs use <= so every consumer sees the pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= ST_ID;
      digits    <= '0;
      sel       <= '0;
      tries     <= '0;
      timer     <= '0;
      ID        <= '0;
      Password  <= '0;
      Control   <= '0;
      Request   <= '0;
      Back      <= 1'b0;
      Eject     <= 1'b0;
      Locked    <= 1'b0;
      BalErr    <= 1'b0;
      KeyReject <= 1'b0;
    end else begin
      Control   <= 3'b000;
      Back      <= 1'b0;
      Eject     <= 1'b0;
      KeyReject <= 1'b0;
      // NOTE: the set sits above every clear so a same-cycle clear overrides it.
      if (bal_hit && (state == ST_MENU || state == ST_AMOUNT)) BalErr <= 1'b1;

      case (state)
        ST_WAIT: begin
          if (KeyValid) KeyReject <= 1'b1;
          if (timer != '0) timer <= timer - TW'(1);
          else if (pass_ok) begin
            state  <= ST_MENU;
            tries  <= '0;
            sel    <= '0;
            digits <= '0;
          end else begin
            tries <= tries + 4'd1;
            if (tries + 4'd1 == TRY_LIMIT) begin
              state  <= ST_LOCK;
              Locked <= 1'b1;
              timer  <= LOCK_LOAD;
            end else begin
              state    <= ST_PASS;
              Password <= '0;
              digits   <= '0;
            end
          end
        end

        ST_LOCK: begin
          if (KeyValid) KeyReject <= 1'b1;
          if (timer != '0) timer <= timer - TW'(1);
          else begin
            state    <= ST_ID;
            Locked   <= 1'b0;
            ID       <= '0;
            Password <= '0;
            tries    <= '0;
            digits   <= '0;
          end
        end

        default: if (KeyValid) begin
          if (is_digit) begin
            if (state == ST_MENU) begin
              if (digit >= 4'd2 && digit <= 4'd5) sel <= digit[2:0];
              else KeyReject <= 1'b1;
            end else if (digits == 2'd2) begin
              KeyReject <= 1'b1;
            end else begin
              digits <= digits + 2'd1;
              case (state)
                ST_ID:   ID       <= field_shift;
                ST_PASS: Password <= field_shift;
                default: Request  <= field_shift;
              endcase
            end
          end else begin
            case (KeyCode)
              K_ENTER: begin
                if (state == ST_MENU) begin
                  if (sel == 3'b000) KeyReject <= 1'b1;
                  else if (sel == 3'b011 || sel == 3'b100) begin
                    state   <= ST_AMOUNT;
                    Request <= '0;
                    digits  <= '0;
                  end else begin
                    Control <= sel;
                    sel     <= '0;
                    BalErr  <= 1'b0;
                  end
                end else if (digits != 2'd2) begin
                  KeyReject <= 1'b1;
                end else begin
                  digits <= '0;
                  case (state)
                    ST_ID: state <= ST_PASS;
                    ST_PASS: begin
                      state <= ST_WAIT;
                      timer <= WAIT_LOAD;
                    end
                    default: begin
                      Control <= sel;
                      sel     <= '0;
                      BalErr  <= 1'b0;
                      state   <= ST_MENU;
                    end
                  endcase
                end
              end
              K_CLEAR: begin
                if (state == ST_MENU) KeyReject <= 1'b1;
                else begin
                  digits <= '0;
                  case (state)
                    ST_ID:   ID       <= '0;
                    ST_PASS: Password <= '0;
                    default: Request  <= '0;
                  endcase
                end
              end
              K_BACK: begin
                if (state == ST_MENU || state == ST_AMOUNT) begin
                  Back   <= 1'b1;
                  sel    <= '0;
                  digits <= '0;
                  state  <= ST_MENU;
                end else begin
                  KeyReject <= 1'b1;
                end
              end
              K_EJECT: begin
                // Retry count survives so ejecting cannot dodge the lockout.
                Eject    <= 1'b1;
                ID       <= '0;
                Password <= '0;
                Request  <= '0;
                sel      <= '0;
                digits   <= '0;
                BalErr   <= 1'b0;
                state    <= ST_ID;
              end
              default: KeyReject <= 1'b1;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atm_keypad_session.sv
// Directed bench for atm_keypad_session: a transaction-level model is compared
// against the DUT every cycle, with literal expectations at key points.
module tb_atm_keypad_session;

  localparam int MAX_TRIES   = 3;
  localparam int RESP_WAIT   = 2;
  localparam int LOCK_CYCLES = 16;

  localparam logic [4:0] K_ENTER = 5'h10;
  localparam logic [4:0] K_CLEAR = 5'h11;
  localparam logic [4:0] K_BACK  = 5'h12;
  localparam logic [4:0] K_EJECT = 5'h13;

  localparam int S_ID = 0, S_PASS = 1, S_WAIT = 2, S_MENU = 3, S_AMT = 4, S_LOCK = 5;

  logic       Clock, Reset, KeyValid, ErrPass, ErrBalance;
  logic [4:0] KeyCode;
  logic [7:0] ID, Password, Request;
  logic [2:0] Control, Stage;
  logic       Back, Eject, Locked, BalErr, KeyReject;

  atm_keypad_session #(
    .MAX_TRIES(MAX_TRIES), .RESP_WAIT(RESP_WAIT), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .Clock(Clock), .Reset(Reset), .KeyValid(KeyValid), .KeyCode(KeyCode),
    .ErrPass(ErrPass), .ErrBalance(ErrBalance), .ID(ID), .Password(Password),
    .Control(Control), .Request(Request), .Back(Back), .Eject(Eject),
    .Stage(Stage), .Locked(Locked), .BalErr(BalErr), .KeyReject(KeyReject)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Session model: fields indexed 0=ID 1=Password 2=Request, timers as absolute deadlines.
  int cyc_n = 0;
  int m_stage = S_ID;
  int m_f[3] = '{0, 0, 0};
  int m_sel = 0, m_cnt = 0, m_tries = 0, m_deadline = 0;
  int m_ctrl = 0, m_back = 0, m_eject = 0, m_rej = 0, m_bal = 0;

  task automatic model_step();
    int kc;
    int fi;
    cyc_n++;
    m_ctrl = 0; m_back = 0; m_eject = 0; m_rej = 0;
    if (Reset) begin
      m_stage = S_ID; m_f = '{0, 0, 0};
      m_sel = 0; m_cnt = 0; m_tries = 0; m_bal = 0;
      return;
    end
    kc = int'(KeyCode);
    fi = (m_stage == S_ID) ? 0 : (m_stage == S_PASS) ? 1 : 2;
    if ((m_stage == S_MENU || m_stage == S_AMT) && ErrBalance) m_bal = 1;
    if (m_stage == S_WAIT || m_stage == S_LOCK) begin
      if (KeyValid) m_rej = 1;
      if (cyc_n == m_deadline) begin
        if (m_stage == S_LOCK) begin
          m_stage = S_ID; m_f[0] = 0; m_f[1] = 0; m_tries = 0; m_cnt = 0;
        end else if (!ErrPass) begin
          m_stage = S_MENU; m_tries = 0; m_sel = 0; m_cnt = 0;
        end else begin
          m_tries++;
          if (m_tries >= MAX_TRIES) begin
            m_stage = S_LOCK; m_deadline = cyc_n + LOCK_CYCLES;
          end else begin
            m_stage = S_PASS; m_f[1] = 0; m_cnt = 0;
          end
        end
      end
    end else if (KeyValid) begin
      if (kc < 16) begin
        if (m_stage == S_MENU) begin
          if (kc >= 2 && kc <= 5) m_sel = kc; else m_rej = 1;
        end else if (m_cnt >= 2) m_rej = 1;
        else begin
          m_f[fi] = (m_f[fi] * 16 + kc) % 256;
          m_cnt++;
        end
      end else if (kc == 16) begin
        if (m_stage == S_MENU) begin
          if (m_sel == 0) m_rej = 1;
          else if (m_sel == 3 || m_sel == 4) begin
            m_stage = S_AMT; m_f[2] = 0; m_cnt = 0;
          end else begin
            m_ctrl = m_sel; m_sel = 0; m_bal = 0;
          end
        end else if (m_cnt < 2) m_rej = 1;
        else begin
          m_cnt = 0;
          if (m_stage == S_ID) m_stage = S_PASS;
          else if (m_stage == S_PASS) begin
            m_stage = S_WAIT; m_deadline = cyc_n + RESP_WAIT;
          end else begin
            m_ctrl = m_sel; m_sel = 0; m_bal = 0; m_stage = S_MENU;
          end
        end
      end else if (kc == 17) begin
        if (m_stage == S_MENU) m_rej = 1;
        else begin m_f[fi] = 0; m_cnt = 0; end
      end else if (kc == 18) begin
        if (m_stage == S_MENU || m_stage == S_AMT) begin
          m_back = 1; m_sel = 0; m_cnt = 0; m_stage = S_MENU;
        end else m_rej = 1;
      end else if (kc == 19) begin
        m_eject = 1; m_f = '{0, 0, 0}; m_sel = 0; m_cnt = 0; m_bal = 0; m_stage = S_ID;
      end else m_rej = 1;
    end
  endtask

  initial forever begin
    @(posedge Clock);
    model_step();
  end

  initial forever begin
    @(negedge Clock);
    if (checking) begin
      check("cmp_ID", ID, m_f[0]);
      check("cmp_Password", Password, m_f[1]);
      check("cmp_Request", Request, m_f[2]);
      check("cmp_Control", Control, m_ctrl);
      check("cmp_Back", Back, m_back);
      check("cmp_Eject", Eject, m_eject);
      check("cmp_Stage", Stage, m_stage);
      check("cmp_Locked", Locked, (m_stage == S_LOCK) ? 1 : 0);
      check("cmp_BalErr", BalErr, m_bal);
      check("cmp_KeyReject", KeyReject, m_rej);
    end
  end

  task automatic drive(input logic kv, input logic [4:0] kc);
    KeyValid = kv;
    KeyCode  = kc;
    @(negedge Clock);
  endtask

  task automatic key(input logic [4:0] kc);
    drive(1'b1, kc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 5'h00);
  endtask

  task automatic enter_pw(input logic [3:0] a, input logic [3:0] b, input logic ep);
    key({1'b0, a});
    key({1'b0, b});
    ErrPass = ep;
    key(K_ENTER);
    idle(RESP_WAIT);
    ErrPass = 1'b0;
  endtask

  task automatic enter_id(input logic [3:0] a, input logic [3:0] b);
    key({1'b0, a});
    key({1'b0, b});
    key(K_ENTER);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ID"}, ID, 0);
    check({tag, "_Password"}, Password, 0);
    check({tag, "_Request"}, Request, 0);
    check({tag, "_Control"}, Control, 0);
    check({tag, "_Stage"}, Stage, 0);
    check({tag, "_Locked"}, Locked, 0);
    check({tag, "_BalErr"}, BalErr, 0);
    check({tag, "_flags"}, {Back, Eject, KeyReject}, 0);
  endtask

  int n_locked;

  initial begin
    Reset = 1'b1; KeyValid = 1'b0; KeyCode = 5'h00; ErrPass = 1'b0; ErrBalance = 1'b0;
    repeat (2) @(negedge Clock);
    check_all_zero("reset");
    checking = 1'b1;
    Reset = 1'b0;

    // ID field: saturation, CLEAR, short ENTER, BACK rejected
    key(5'h01); key(5'h02);
    key(5'h03);
    check("third_digit_reject", KeyReject, 1);
    check("third_digit_id", ID, 8'h12);
    key(K_CLEAR);
    check("clear_id", ID, 0);
    key(5'h01);
    key(K_ENTER);
    check("short_enter_reject", KeyReject, 1);
    check("short_enter_stage", Stage, 0);
    key(K_BACK);
    check("back_in_id_reject", KeyReject, 1);
    key(K_CLEAR);

    // Successful login with WAIT timing
    enter_id(4'h1, 4'h2);
    check("id_to_pass", Stage, 1);
    key(5'h0A); key(5'h05);
    key(K_ENTER);
    check("wait_stage_1", Stage, 2);
    check("wait_id", ID, 8'h12);
    check("wait_pw", Password, 8'hA5);
    idle(1);
    check("wait_stage_2", Stage, 2);
    idle(1);
    check("menu_stage", Stage, 3);
    check("menu_pw_held", Password, 8'hA5);

    // Withdraw 0x40, then balance error handling
    key(5'h03); key(K_ENTER);
    check("amount_stage", Stage, 4);
    key(5'h04); key(5'h00); key(K_ENTER);
    check("withdraw_control", Control, 3'b011);
    check("withdraw_request", Request, 8'h40);
    check("withdraw_stage", Stage, 3);
    idle(1);
    check("control_one_cycle", Control, 0);
    ErrBalance = 1'b1; idle(1);
    check("balerr_set", BalErr, 1);
    ErrBalance = 1'b0; idle(1);
    check("balerr_sticky", BalErr, 1);
    key(5'h07);
    check("menu_bad_digit", KeyReject, 1);
    key(K_ENTER);
    check("menu_enter_nosel", KeyReject, 1);
    ErrBalance = 1'b1;
    key(5'h02);
    key(K_ENTER);
    check("show_control", Control, 3'b010);
    check("clear_wins", BalErr, 0);
    ErrBalance = 1'b0;
    idle(1);

    // BACK and EJECT
    key(K_BACK);
    check("back_pulse", Back, 1);
    check("back_stage", Stage, 3);
    idle(1);
    check("back_one_cycle", Back, 0);
    key(5'h04); key(K_ENTER); key(5'h09);
    key(K_BACK);
    check("back_from_amount", Stage, 3);
    ErrBalance = 1'b1; idle(1); ErrBalance = 1'b0;
    key(K_EJECT);
    check("eject_pulse", Eject, 1);
    check("eject_id", ID, 0);
    check("eject_pw", Password, 0);
    check("eject_req", Request, 0);
    check("eject_balerr", BalErr, 0);
    check("eject_stage", Stage, 0);
    idle(1);
    check("eject_one_cycle", Eject, 0);
    key(5'h15);
    check("invalid_code", KeyReject, 1);

    // Two failures, EJECT, one more failure must still lock
    enter_id(4'h3, 4'h4);
    enter_pw(4'h1, 4'h1, 1'b1);
    check("fail1_stage", Stage, 1);
    check("fail1_pw", Password, 0);
    enter_pw(4'h1, 4'h1, 1'b1);
    key(K_EJECT);
    enter_id(4'h3, 4'h4);
    enter_pw(4'h1, 4'h1, 1'b1);
    check("lock_stage", Stage, 5);
    n_locked = 1;
    for (int i = 0; i < 40; i++) begin
      drive(i == 3, 5'h05);
      if (i == 3) check("lock_key_reject", KeyReject, 1);
      if (Locked) n_locked++;
      else break;
    end
    check("lock_cycles", n_locked, LOCK_CYCLES);
    check("unlock_stage", Stage, 0);
    check("unlock_id", ID, 0);

    // Tries cleared after lockout: two failures then success
    enter_id(4'h3, 4'h4);
    enter_pw(4'h1, 4'h1, 1'b1);
    enter_pw(4'h1, 4'h1, 1'b1);
    enter_pw(4'h2, 4'h2, 1'b0);
    check("relogin_menu", Stage, 3);

    // Reset mid-AMOUNT wins over a concurrent key
    key(5'h03); key(K_ENTER); key(5'h01);
    Reset = 1'b1;
    key(5'h02);
    check_all_zero("midreset");
    Reset = 1'b0;
    idle(2);

    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
